// File: rtl/fc_layer_scheduler_if.sv
// Purpose : bundles the control, memory-read and output-handshake signals of
//           fc_layer_scheduler into one interface.
// Ports   : start/busy/done control; feat_addr/feat_data and w_addr/w_data
//           memory reads (1-cycle latency); out_valid/out_ready/out_idx/out_data.
// Modports: slave = scheduler side, master = environment (memories + consumer).
interface fc_layer_scheduler_if #(
  parameter int BITWIDTH = 32,
  parameter int N_IN     = 10,
  parameter int N_OUT    = 10
);
  localparam int FA_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
  localparam int OI_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic                start;
  logic                busy;
  logic                done;
  logic [FA_W-1:0]     feat_addr;
  logic [BITWIDTH-1:0] feat_data;
  logic [WA_W-1:0]     w_addr;
  logic [BITWIDTH-1:0] w_data;
  logic                out_valid;
  logic                out_ready;
  logic [OI_W-1:0]     out_idx;
  logic [BITWIDTH-1:0] out_data;

  modport slave (
    input  start, feat_data, w_data, out_ready,
    output busy, done, feat_addr, w_addr, out_valid, out_idx, out_data
  );

  modport master (
    output start, feat_data, w_data, out_ready,
    input  busy, done, feat_addr, w_addr, out_valid, out_idx, out_data
  );
endinterface

// File: rtl/fc_layer_scheduler.sv
// Purpose : sequences a single MAC over out[i] = sum_j feat[j]*W[i][j], reading
//           features/weights from 1-cycle-latency memories, one row at a time.
// Latency : N_IN+2 cycles per row (N_IN issue, 1 drain, 1 emit); done pulses
//           N_OUT*(N_IN+2)+1 cycles after start with out_ready held high.
// Backpressure: EMIT holds out_valid/out_idx/out_data stable until out_ready.
// Ports   : clk, rst (synchronous, active high), bus (fc_layer_scheduler_if.slave).
// Macro   : FC_RELU_EN -- when defined, emitted values are clamped to zero if
//           negative; the accumulator itself is never clamped.
module fc_layer_scheduler #(
  parameter int BITWIDTH = 32,
  parameter int N_IN     = 10,
  parameter int N_OUT    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  fc_layer_scheduler_if.slave     bus
);
  localparam int FA_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
  localparam int OI_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [FA_W-1:0] J_LAST = FA_W'(N_IN - 1);
  localparam logic [OI_W-1:0] I_LAST = OI_W'(N_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_EMIT,
    S_DONE
  } state_t;

  state_t              state_q;
  logic                busy_q;
  logic                done_q;
  logic                out_valid_q;
  logic [FA_W-1:0]     feat_addr_q;  // doubles as the column counter j
  logic [WA_W-1:0]     w_addr_q;
  logic [OI_W-1:0]     out_idx_q;    // doubles as the row counter i
  logic [BITWIDTH-1:0] acc_q;
  logic [BITWIDTH-1:0] out_data_q;

  logic [BITWIDTH-1:0] prod_d;
  logic [BITWIDTH-1:0] acc_d;
  logic [BITWIDTH-1:0] emit_d;

  // Low BITWIDTH bits of the product are identical for signed and unsigned
  // operands, so plain unsigned arithmetic gives two's-complement wrap.
  assign prod_d = bus.feat_data * bus.w_data;
  assign acc_d  = acc_q + prod_d;

`ifdef FC_RELU_EN
  assign emit_d = acc_d[BITWIDTH-1] ? '0 : acc_d;
`else
  assign emit_d = acc_d;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.out_valid = out_valid_q;
  assign bus.feat_addr = feat_addr_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_data  = out_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      feat_addr_q <= '0;
      w_addr_q    <= '0;
      out_idx_q   <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q     <= S_ISSUE;
            busy_q      <= 1'b1;
            feat_addr_q <= '0;
            w_addr_q    <= '0;
            out_idx_q   <= '0;
            acc_q       <= '0;
          end
        end
        S_ISSUE: begin
          // Read data trails the address by one cycle, so the j=0 cycle has
          // nothing of this row to accumulate yet.
          if (feat_addr_q != '0) begin
            acc_q <= acc_d;
          end
          if (feat_addr_q == J_LAST) begin
            state_q <= S_DRAIN;
          end else begin
            feat_addr_q <= feat_addr_q + FA_W'(1);
            w_addr_q    <= w_addr_q + WA_W'(1);
          end
        end
        S_DRAIN: begin
          acc_q       <= acc_d;
          out_data_q  <= emit_d;
          out_valid_q <= 1'b1;
          state_q     <= S_EMIT;
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (out_idx_q == I_LAST) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // Weights are row-major, so the next row starts right after
              // the last address issued, which w_addr_q still holds.
              state_q     <= S_ISSUE;
              out_idx_q   <= out_idx_q + OI_W'(1);
              feat_addr_q <= '0;
              w_addr_q    <= w_addr_q + WA_W'(1);
              acc_q       <= '0;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule
